// File: rtl/cpu_mem_responder.sv
// Memory-side responder for the CPUSystem memory interface: internal RAM served
// with fixed read/write wait-state latency and a one-cycle Mem_Ready completion pulse.
module cpu_mem_responder #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int RD_LAT = 2,
    parameter int WR_LAT = 1
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Mem_CS,
    input  logic              Mem_WR,
    input  logic [ADDR_W-1:0] Address,
    input  logic [DATA_W-1:0] Data_in,
    output logic [DATA_W-1:0] Data_out,
    output logic              Mem_Ready,
    output logic              Mem_Busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_HOLD
    } state_t;

    localparam logic [3:0] RD_LOAD = 4'(RD_LAT - 1);
    localparam logic [3:0] WR_LOAD = 4'(WR_LAT - 1);

    state_t            r_state;
    state_t            w_next;
    logic              w_accept;
    logic              w_done;
    logic [3:0]        r_cnt;
    logic              r_wr;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;
    logic [DATA_W-1:0] r_dout;
    logic              r_ready;
    logic [DATA_W-1:0] r_mem [2**ADDR_W];

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_done   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!Mem_CS) begin
                    w_accept = 1'b1;
                    w_next   = S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_cnt == '0) begin
                    w_done = 1'b1;
                    w_next = S_HOLD;
                end
            end
            // Waiting for CS to go high keeps a held-low CS from re-triggering.
            S_HOLD: begin
                if (Mem_CS) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_cnt   <= '0;
            r_wr    <= 1'b0;
            r_addr  <= '0;
            r_data  <= '0;
            r_dout  <= '0;
            r_ready <= 1'b0;
        end else begin
            r_ready <= w_done;
            if (w_accept) begin
                r_wr   <= Mem_WR;
                r_addr <= Address;
                r_data <= Data_in;
                r_cnt  <= Mem_WR ? WR_LOAD : RD_LOAD;
            end else if (r_state == S_WAIT && !w_done) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_done && !r_wr) r_dout <= r_mem[r_addr];
        end
    end

    // RAM has no reset; an access abandoned by reset never reaches w_done.
    always_ff @(posedge Clock) begin
        if (w_done && r_wr) r_mem[r_addr] <= r_data;
    end

    assign Data_out  = r_dout;
    assign Mem_Ready = r_ready;
    assign Mem_Busy  = (r_state == S_WAIT);

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Self-checking bench for cpu_mem_responder: three instances with different
// latencies, directed cases plus random traffic against a behavioural RAM model.
module tb_cpu_mem_responder;

    logic            Clock = 1'b0;
    logic            Reset;
    logic [2:0]      cs, wr, rdy, busy;
    logic [2:0][7:0] addr, din, dout;

    int errors = 0;
    int checks = 0;

    int         rd_lat [3] = '{2, 1, 15};
    int         wr_lat [3] = '{1, 15, 1};
    logic [7:0] mem_m  [3][256];
    bit         known  [3][256];
    logic [7:0] last_rd[3];

    always #5 Clock = ~Clock;

    cpu_mem_responder #(.ADDR_W(8), .DATA_W(8), .RD_LAT(2), .WR_LAT(1)) u_dut0 (
        .Clock(Clock), .Reset(Reset), .Mem_CS(cs[0]), .Mem_WR(wr[0]), .Address(addr[0]),
        .Data_in(din[0]), .Data_out(dout[0]), .Mem_Ready(rdy[0]), .Mem_Busy(busy[0]));
    cpu_mem_responder #(.ADDR_W(8), .DATA_W(8), .RD_LAT(1), .WR_LAT(15)) u_dut1 (
        .Clock(Clock), .Reset(Reset), .Mem_CS(cs[1]), .Mem_WR(wr[1]), .Address(addr[1]),
        .Data_in(din[1]), .Data_out(dout[1]), .Mem_Ready(rdy[1]), .Mem_Busy(busy[1]));
    cpu_mem_responder #(.ADDR_W(8), .DATA_W(8), .RD_LAT(15), .WR_LAT(1)) u_dut2 (
        .Clock(Clock), .Reset(Reset), .Mem_CS(cs[2]), .Mem_WR(wr[2]), .Address(addr[2]),
        .Data_in(din[2]), .Data_out(dout[2]), .Mem_Ready(rdy[2]), .Mem_Busy(busy[2]));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One complete access on instance d; scramble perturbs all inputs during WAIT.
    task automatic access(input int d, input bit we, input logic [7:0] a,
                          input logic [7:0] wd, input int hold, input bit scramble);
        int n;
        int extra;
        bit got;
        bit busy_ok;
        bit excl_ok;
        @(negedge Clock);
        cs[d] = 1'b0; wr[d] = we; addr[d] = a; din[d] = wd;
        @(posedge Clock);
        n = 0; got = 0; busy_ok = 1; excl_ok = 0;
        while (!got && n < 40) begin
            @(negedge Clock);
            if (scramble) begin
                addr[d] = a ^ 8'h20; din[d] = ~wd; wr[d] = ~we; cs[d] = 1'b1;
            end
            if (rdy[d]) begin
                got = 1;
                excl_ok = !busy[d];
            end else begin
                n++;
                if (!busy[d]) busy_ok = 0;
            end
        end
        check($sformatf("latency d%0d", d), n, we ? wr_lat[d] : rd_lat[d]);
        check($sformatf("busy_in_wait d%0d", d), busy_ok, 1);
        check($sformatf("ready_not_busy d%0d", d), excl_ok, 1);
        if (we) begin
            mem_m[d][a] = wd;
            known[d][a] = 1;
        end else begin
            last_rd[d] = mem_m[d][a];
        end
        check($sformatf("dout d%0d a%0h", d, a), dout[d], last_rd[d]);
        extra = 0;
        repeat (hold + 1) begin
            @(negedge Clock);
            if (rdy[d] || busy[d]) extra++;
        end
        check($sformatf("single_pulse d%0d", d), extra, 0);
        cs[d] = 1'b1;
    endtask

    // Start an access on d and pull reset before it can complete.
    task automatic abandon(input int d, input bit we, input logic [7:0] a, input logic [7:0] wd);
        int extra;
        @(negedge Clock);
        cs[d] = 1'b0; wr[d] = we; addr[d] = a; din[d] = wd;
        @(posedge Clock);
        #1 Reset = 1'b0;
        #1;
        check("rst_dout", dout[d], 0);
        check("rst_ready", rdy[d], 0);
        check("rst_busy", busy[d], 0);
        for (int i = 0; i < 3; i++) last_rd[i] = '0;
        cs[d] = 1'b1;
        @(negedge Clock);
        Reset = 1'b1;
        extra = 0;
        repeat (20) begin
            @(negedge Clock);
            if (rdy[d]) extra++;
        end
        check("rst_no_ready", extra, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a;
        bit we;
        Reset = 1'b0;
        cs = '1; wr = '0; addr = '0; din = '0;
        for (int i = 0; i < 3; i++) begin
            last_rd[i] = '0;
            for (int j = 0; j < 256; j++) known[i][j] = 0;
        end
        repeat (3) @(negedge Clock);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("reset_dout d%0d", i), dout[i], 0);
            check($sformatf("reset_ready d%0d", i), rdy[i], 0);
            check($sformatf("reset_busy d%0d", i), busy[i], 0);
        end
        Reset = 1'b1;

        access(0, 1, 8'h10, 8'hA5, 0, 0);
        access(0, 0, 8'h10, 8'h00, 0, 0);

        abandon(0, 0, 8'h10, 8'h00);
        abandon(0, 1, 8'h10, 8'h77);
        access(0, 0, 8'h10, 8'h00, 0, 0);

        access(0, 1, 8'h20, 8'h5A, 0, 0);
        access(0, 0, 8'h20, 8'h00, 10, 0);

        access(0, 1, 8'h30, 8'hC3, 0, 0);
        access(0, 0, 8'h10, 8'h00, 0, 1);

        access(0, 1, 8'hFF, 8'h3C, 0, 0);
        access(0, 0, 8'hFF, 8'h00, 0, 0);

        for (int d = 1; d < 3; d++) begin
            access(d, 1, 8'h00, 8'h81, 0, 0);
            access(d, 0, 8'h00, 8'h00, 0, 0);
            access(d, 1, 8'hFF, 8'h7E, 2, 0);
            access(d, 0, 8'hFF, 8'h00, 3, 1);
        end

        for (int d = 0; d < 3; d++) begin
            for (int k = 0; k < 15; k++) begin
                we = $urandom_range(0, 1) == 1;
                a = $urandom_range(0, 255);
                if (!we) begin
                    for (int s = 0; s < 256 && !known[d][a[7:0]]; s++) a = (a + 1) % 256;
                end
                access(d, we, a[7:0], 8'($urandom), $urandom_range(0, 2), $urandom_range(0, 1) == 1);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
